alu_mdu: RTL and testbench
==========================

# alu_mdu

Parametrised, multi-cycle integer execute unit for the RISCV64 core. It succeeds the purely combinational ALU and covers the RV base ALU operations, the RV64 W-suffix operations and the M-extension multiply/divide/remainder. Operands enter through a valid/ready handshake and results leave through one, with one operation in flight at a time. The block sits in the execute stage; a stall is raised while `in_ready` is low.

## Interface
- `XLEN`, 64: datapath width; legal values are 32 and 64.
- `SHAMT_BITS`, $clog2(XLEN): shift-amount width taken from B.
- `clk` input 1: clock; all state updates on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `flush` input 1: synchronous abort of the in-flight operation.
- `in_valid` input 1: request valid.
- `in_ready` output 1: the unit accepts a request; high only in IDLE.
- `in_op` input 5: operation code (see Operation).
- `in_a` input XLEN: operand A.
- `in_b` input XLEN: operand B.
- `out_valid` output 1: result valid.
- `out_ready` input 1: consumer accepts the result.
- `out_result` output XLEN: result.
- `out_illegal` output 1: the op code is unsupported; `out_result` is 0.

## Operation
- Op codes:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SLT, 7 SLTU, 8 SRL, 9 SRA, 10 PASSB (LUI).
  - 11 ADDW, 12 SUBW, 13 SLLW, 14 SRLW, 15 SRAW.
  - 16 MUL, 17 MULH, 18 MULHSU, 19 MULHU.
  - 20 DIV, 21 DIVU, 22 REM, 23 REMU.
  - 24 MULW, 25 DIVW, 26 DIVUW, 27 REMW, 28 REMUW.
  - 29–31 are illegal. Codes 11–15 and 24–28 are also illegal when XLEN=32.
- Shifts use `in_b[SHAMT_BITS-1:0]`; W shifts use `in_b[4:0]`.
- Every W op sign-extends bit 31 of its 32-bit result to XLEN, SRLW included.
- Arithmetic wraps modulo 2^XLEN (modulo 2^32 for W ops). Flags exist only for illegal ops.
- FSM states:
  - IDLE: on `in_valid`, latch op/A/B. Single-cycle ops, illegal ops and divide fast paths go to DONE. MUL* goes to MUL. DIV*/REM* goes to DIV.
  - MUL: shift-add, one multiplier bit per cycle, over N iterations. N=XLEN, or 32 for MULW. Signed operands are converted to magnitude first and the product is negated at the end per the RV signedness rules. Goes to DONE after N iterations.
  - DIV: restoring division, one quotient bit per cycle, N iterations. Signs are fixed up at the end: the quotient sign is sign(A)^sign(B) and the remainder takes the sign of A. Goes to DONE.
  - DONE: `out_valid`=1, result held stable. On `out_ready`, go to IDLE.
- Divide fast paths, result in DONE without iterating:
  - Divisor 0: quotient = all ones, remainder = A. For W ops, the 32-bit values are then sign-extended.
  - Signed overflow (A = most-negative, B = −1): quotient = A, remainder = 0.
- `flush` in any state: go to IDLE, `out_valid`=0, no result produced. `flush` takes priority over `in_valid` in the same cycle, so no request is accepted.
- `rst` asserted at any time, including mid-iteration: immediate return to IDLE.

## Timing
- Reset values: `in_ready`=1, `out_valid`=0, `out_result`=0, `out_illegal`=0. Internal counters and accumulators are cleared.
- Latency is counted from the accepting edge, where `in_valid` and `in_ready` are both high:
  - Single-cycle ops, illegal ops and fast paths: `out_valid` high after 1 edge.
  - MUL/DIV: `out_valid` high after N+1 edges, i.e. 65 for 64-bit ops and 33 for W ops.
- `in_ready` = (state==IDLE). No new request is accepted in the edge where DONE hands off, so back-to-back single-cycle throughput is one op per 2 cycles.
- `out_result` and `out_illegal` are registered and held constant while `out_valid`=1 and `out_ready`=0.
- Inputs are sampled only at the accepting edge. Later changes to `in_a`/`in_b` have no effect.

## Configuration
- Macro `ALU_MDU_MULDIV_EN`.
- Defined: the MUL and DIV states are built and ops 16–28 are supported as above.
- Undefined: the MUL/DIV datapaths are removed and ops 16–28 are reported illegal with a 1-edge latency. Ops 0–15 behave identically in both builds.

## Test plan
- Reset: assert `rst` mid-MUL at iteration 10 → outputs return to their reset values at once. After release, `in_ready`=1 and there is no spurious `out_valid`.
- Single-cycle ops at XLEN=64:
  - SRA A=0x8000_0000_0000_0000, B=0x43 (shamt 3) → 0xF000_0000_0000_0000 after 1 edge.
  - SRLW A=0x0000_0000_8000_0000, B=0 → 0xFFFF_FFFF_8000_0000.
- MULH A=−2, B=3 → 0xFFFF_FFFF_FFFF_FFFF after 65 edges. MULW A=0x7FFF_FFFF, B=2 → 0xFFFF_FFFF_FFFF_FFFE after 33 edges.
- Divide corners:
  - DIV by 0 with A=5 → 0xFFFF…FFFF after 1 edge; REMU by 0 with A=5 → 5.
  - DIV A=0x8000…0, B=−1 → 0x8000…0.
  - REM A=−7, B=2 → −1.
- Backpressure/flush: hold `out_ready`=0 for 20 cycles after DIVU 100/7 → `out_result`=14 held stable, `in_ready`=0. Assert `flush` during a new DIV → IDLE with no output.
- Build without `ALU_MDU_MULDIV_EN`: MUL op → `out_illegal`=1 and `out_result`=0 after 1 edge. ADD 3+4 → 7. Op 31 → illegal in both builds.

Source files
------------

// File: rtl/alu_mdu.sv
// alu_mdu: multi-cycle RV64 integer execute unit with base ALU, W and M-extension ops.
// Define ALU_MDU_MULDIV_EN to build the shift-add multiplier and restoring divider.
module alu_mdu #(
  parameter int XLEN       = 64,
  parameter int SHAMT_BITS = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      in_op,
  input  logic [XLEN-1:0] in_a,
  input  logic [XLEN-1:0] in_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic            out_illegal
);
  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t          state_reg, state_next;
  logic [XLEN-1:0] result_reg, result_next;
  logic            illegal_reg, illegal_next;
  logic [XLEN-1:0] alu_res;
  logic            op_illegal;
  logic [31:0]     a32, b32;

  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    logic [XLEN-1:0] r;
    r       = {XLEN{v[31]}};
    r[31:0] = v;
    return r;
  endfunction

  assign a32 = in_a[31:0];
  assign b32 = in_b[31:0];

  always_comb begin
    alu_res = '0;
    case (in_op)
      5'd0:    alu_res = in_a + in_b;
      5'd1:    alu_res = in_a - in_b;
      5'd2:    alu_res = in_a & in_b;
      5'd3:    alu_res = in_a | in_b;
      5'd4:    alu_res = in_a ^ in_b;
      5'd5:    alu_res = in_a << in_b[SHAMT_BITS-1:0];
      5'd6:    alu_res[0] = $signed(in_a) < $signed(in_b);
      5'd7:    alu_res[0] = in_a < in_b;
      5'd8:    alu_res = in_a >> in_b[SHAMT_BITS-1:0];
      5'd9:    alu_res = $signed(in_a) >>> in_b[SHAMT_BITS-1:0];
      5'd10:   alu_res = in_b;
      5'd11:   alu_res = sext32(a32 + b32);
      5'd12:   alu_res = sext32(a32 - b32);
      5'd13:   alu_res = sext32(a32 << in_b[4:0]);
      5'd14:   alu_res = sext32(a32 >> in_b[4:0]);
      5'd15:   alu_res = sext32($signed(a32) >>> in_b[4:0]);
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    op_illegal = (in_op >= 5'd29);
    if (XLEN != 64 && ((in_op >= 5'd11 && in_op <= 5'd15) || in_op >= 5'd24))
      op_illegal = 1'b1;
`ifndef ALU_MDU_MULDIV_EN
    if (in_op >= 5'd16)
      op_illegal = 1'b1;
`endif
  end

`ifdef ALU_MDU_MULDIV_EN
  // shift_reg holds the multiplier (shifting right) or dividend/quotient (shifting left)
  logic [4:0]            op_reg, op_next;
  logic [SHAMT_BITS-1:0] cnt_reg, cnt_next;
  logic [2*XLEN-1:0]     acc_reg, acc_next, mcand_reg, mcand_next;
  logic [XLEN-1:0]       shift_reg, shift_next, rem_reg, rem_next, dsor_reg, dsor_next;
  logic                  neg_reg, neg_next, negr_reg, negr_next;

  logic                  in_mul, in_div, in_w, in_rem, sa, sb, a_neg, b_neg, div0, div_ovf;
  logic [XLEN-1:0]       a_op, b_op, a_mag, b_mag, a_sx;
  logic                  r_w, r_rem, last, q_bit;
  logic [2*XLEN-1:0]     acc_sum, prod;
  logic [XLEN:0]         rem_sh, diff;
  logic [XLEN-1:0]       rem_step, quo_step, div_raw, div_res, mul_res;

  function automatic logic [XLEN-1:0] zext32(input logic [31:0] v);
    logic [XLEN-1:0] r;
    r       = '0;
    r[31:0] = v;
    return r;
  endfunction

  assign in_mul  = (in_op >= 5'd16 && in_op <= 5'd19) || in_op == 5'd24;
  assign in_div  = (in_op >= 5'd20 && in_op <= 5'd23) || (in_op >= 5'd25 && in_op <= 5'd28);
  assign in_w    = in_op >= 5'd24;
  assign in_rem  = in_op == 5'd22 || in_op == 5'd23 || in_op == 5'd27 || in_op == 5'd28;
  assign sa      = in_op == 5'd17 || in_op == 5'd18 || in_op == 5'd20 || in_op == 5'd22 ||
                   in_op == 5'd25 || in_op == 5'd27;
  assign sb      = in_op == 5'd17 || in_op == 5'd20 || in_op == 5'd22 ||
                   in_op == 5'd25 || in_op == 5'd27;
  assign a_op    = in_w ? (sa ? sext32(a32) : zext32(a32)) : in_a;
  assign b_op    = in_w ? (sb ? sext32(b32) : zext32(b32)) : in_b;
  assign a_neg   = sa & a_op[XLEN-1];
  assign b_neg   = sb & b_op[XLEN-1];
  assign a_mag   = a_neg ? -a_op : a_op;
  assign b_mag   = b_neg ? -b_op : b_op;
  assign a_sx    = in_w ? sext32(a32) : in_a;
  assign div0    = in_w ? (b32 == '0) : (in_b == '0);
  assign div_ovf = sa && (in_w ? (a32 == 32'h8000_0000 && b32 == '1)
                               : (in_a == {1'b1, {(XLEN-1){1'b0}}} && in_b == '1));

  assign r_w     = op_reg >= 5'd24;
  assign r_rem   = op_reg == 5'd22 || op_reg == 5'd23 || op_reg == 5'd27 || op_reg == 5'd28;
  assign last    = cnt_reg == (r_w ? SHAMT_BITS'(31) : SHAMT_BITS'(XLEN-1));

  assign acc_sum = shift_reg[0] ? acc_reg + mcand_reg : acc_reg;
  assign prod    = neg_reg ? -acc_sum : acc_sum;

  // No borrow out of the trial subtraction means the partial remainder covers the divisor
  assign rem_sh   = {rem_reg, shift_reg[XLEN-1]};
  assign diff     = rem_sh - {1'b0, dsor_reg};
  assign q_bit    = ~diff[XLEN];
  assign rem_step = q_bit ? diff[XLEN-1:0] : rem_sh[XLEN-1:0];
  assign quo_step = {shift_reg[XLEN-2:0], q_bit};
  assign div_raw  = r_rem ? (negr_reg ? -rem_step : rem_step) : (neg_reg ? -quo_step : quo_step);
  assign div_res  = r_w ? sext32(div_raw[31:0]) : div_raw;

  always_comb begin
    mul_res = prod[2*XLEN-1:XLEN];
    if (op_reg == 5'd16)
      mul_res = prod[XLEN-1:0];
    else if (op_reg == 5'd24)
      mul_res = sext32(prod[31:0]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_reg    <= '0;
      cnt_reg   <= '0;
      acc_reg   <= '0;
      mcand_reg <= '0;
      shift_reg <= '0;
      rem_reg   <= '0;
      dsor_reg  <= '0;
      neg_reg   <= 1'b0;
      negr_reg  <= 1'b0;
    end else begin
      op_reg    <= op_next;
      cnt_reg   <= cnt_next;
      acc_reg   <= acc_next;
      mcand_reg <= mcand_next;
      shift_reg <= shift_next;
      rem_reg   <= rem_next;
      dsor_reg  <= dsor_next;
      neg_reg   <= neg_next;
      negr_reg  <= negr_next;
    end
  end
`endif

  always_comb begin
    state_next   = state_reg;
    result_next  = result_reg;
    illegal_next = illegal_reg;
`ifdef ALU_MDU_MULDIV_EN
    op_next    = op_reg;
    cnt_next   = cnt_reg;
    acc_next   = acc_reg;
    mcand_next = mcand_reg;
    shift_next = shift_reg;
    rem_next   = rem_reg;
    dsor_next  = dsor_reg;
    neg_next   = neg_reg;
    negr_next  = negr_reg;
`endif
    if (flush) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE: if (in_valid) begin
          state_next   = DONE;
          illegal_next = op_illegal;
          result_next  = op_illegal ? '0 : alu_res;
`ifdef ALU_MDU_MULDIV_EN
          if (!op_illegal && in_mul) begin
            state_next = MUL;
            op_next    = in_op;
            cnt_next   = '0;
            acc_next   = '0;
            mcand_next = {{XLEN{1'b0}}, a_mag};
            shift_next = b_mag;
            neg_next   = a_neg ^ b_neg;
          end else if (!op_illegal && in_div) begin
            if (div0) begin
              result_next = in_rem ? a_sx : '1;
            end else if (div_ovf) begin
              result_next = in_rem ? '0 : a_sx;
            end else begin
              state_next = DIV;
              op_next    = in_op;
              cnt_next   = '0;
              rem_next   = '0;
              shift_next = in_w ? (a_mag << (XLEN-32)) : a_mag;
              dsor_next  = b_mag;
              neg_next   = a_neg ^ b_neg;
              negr_next  = a_neg;
            end
          end
`endif
        end
`ifdef ALU_MDU_MULDIV_EN
        MUL: begin
          acc_next   = acc_sum;
          mcand_next = mcand_reg << 1;
          shift_next = shift_reg >> 1;
          cnt_next   = cnt_reg + 1'b1;
          if (last) begin
            state_next  = DONE;
            result_next = mul_res;
          end
        end
        DIV: begin
          rem_next   = rem_step;
          shift_next = quo_step;
          cnt_next   = cnt_reg + 1'b1;
          if (last) begin
            state_next  = DONE;
            result_next = div_res;
          end
        end
`endif
        DONE: if (out_ready) state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      result_reg  <= '0;
      illegal_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      result_reg  <= result_next;
      illegal_reg <= illegal_next;
    end
  end

  assign in_ready    = (state_reg == IDLE);
  assign out_valid   = (state_reg == DONE);
  assign out_result  = result_reg;
  assign out_illegal = illegal_reg;
endmodule

// File: tb/tb_alu_mdu.sv
// tb_alu_mdu: randomized and directed checks of alu_mdu (XLEN=64) against a behavioural model.
// Follows the ALU_MDU_MULDIV_EN build of the design.
module tb_alu_mdu;
  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, out_valid, out_ready, out_illegal;
  logic [4:0]  in_op;
  logic [63:0] in_a, in_b, out_result;
  int          n_checks = 0;
  int          n_fail   = 0;

  localparam logic [63:0] MIN64 = 64'h8000_0000_0000_0000;

  always #5 clk = ~clk;

  alu_mdu #(.XLEN(64)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_a(in_a), .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_illegal(out_illegal)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] sx(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

  // Architectural result, illegal flag and latency in edges for one request
  function automatic void ref_model(input int op, input logic [63:0] a, input logic [63:0] b,
                                    output logic [63:0] r, output logic ill, output int lat);
    logic signed [63:0]  sa, sb;
    logic [31:0]         a32, b32;
    logic signed [31:0]  sa32, sb32;
    logic signed [127:0] pa, pb;
    logic [127:0]        ua, ub, pu;
    logic                ovf32;
    sa = a; sb = b; a32 = a[31:0]; b32 = b[31:0]; sa32 = a32; sb32 = b32;
    pa = sa; pb = sb; ua = a; ub = b;
    ovf32 = (a32 == 32'h8000_0000) && (b32 == 32'hFFFF_FFFF);
    r = '0; ill = 1'b0; lat = 1;
    case (op)
      0:  r = a + b;
      1:  r = a - b;
      2:  r = a & b;
      3:  r = a | b;
      4:  r = a ^ b;
      5:  r = a << b[5:0];
      6:  r = (sa < sb) ? 64'd1 : 64'd0;
      7:  r = (a < b) ? 64'd1 : 64'd0;
      8:  r = a >> b[5:0];
      9:  r = sa >>> b[5:0];
      10: r = b;
      11: r = sx(a32 + b32);
      12: r = sx(a32 - b32);
      13: r = sx(a32 << b[4:0]);
      14: r = sx(a32 >> b[4:0]);
      15: r = sx(sa32 >>> b[4:0]);
      16: begin r = a * b; lat = 65; end
      17: begin pu = pa * pb; r = pu[127:64]; lat = 65; end
      18: begin pu = pa * $signed(ub); r = pu[127:64]; lat = 65; end
      19: begin pu = ua * ub; r = pu[127:64]; lat = 65; end
      20: if (b == 0) r = '1; else if (a == MIN64 && b == '1) r = a; else begin r = sa / sb; lat = 65; end
      21: if (b == 0) r = '1; else begin r = a / b; lat = 65; end
      22: if (b == 0) r = a; else if (a == MIN64 && b == '1) r = 0; else begin r = sa % sb; lat = 65; end
      23: if (b == 0) r = a; else begin r = a % b; lat = 65; end
      24: begin r = sx(a32 * b32); lat = 33; end
      25: if (b32 == 0) r = '1; else if (ovf32) r = sx(a32); else begin r = sx(sa32 / sb32); lat = 33; end
      26: if (b32 == 0) r = '1; else begin r = sx(a32 / b32); lat = 33; end
      27: if (b32 == 0) r = sx(a32); else if (ovf32) r = 0; else begin r = sx(sa32 % sb32); lat = 33; end
      28: if (b32 == 0) r = sx(a32); else begin r = sx(a32 % b32); lat = 33; end
      default: ill = 1'b1;
    endcase
`ifndef ALU_MDU_MULDIV_EN
    if (op >= 16) begin ill = 1'b1; lat = 1; end
`endif
    if (ill) r = '0;
  endfunction

  function automatic logic [63:0] pick();
    case ($urandom_range(0, 9))
      0:       return 64'd0;
      1:       return '1;
      2:       return MIN64;
      3:       return 64'hFFFF_FFFF_8000_0000;
      4:       return 64'($urandom_range(0, 20));
      5:       return -64'($urandom_range(1, 20));
      default: return {$urandom, $urandom};
    endcase
  endfunction

  task automatic issue(input int op, input logic [63:0] a, input logic [63:0] b);
    @(negedge clk);
    check("in_ready", in_ready, 1'b1);
    in_valid = 1'b1; in_op = 5'(op); in_a = a; in_b = b;
    @(posedge clk); #1;
    in_valid = 1'b0; in_op = 5'($urandom); in_a = {$urandom, $urandom}; in_b = {$urandom, $urandom};
  endtask

  task automatic wait_valid(output int n);
    n = 1;
    while (!out_valid && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic run_chk(input int op, input logic [63:0] a, input logic [63:0] b,
                         input logic [63:0] er, input logic ei, input int el);
    int n;
    issue(op, a, b);
    wait_valid(n);
    check("latency", 64'(n), 64'(el));
    check("result", out_result, er);
    check("illegal", out_illegal, ei);
    $display("op=%0d a=%h b=%h result=%h illegal=%0d latency=%0d", op, a, b, out_result, out_illegal, n);
    if (!out_valid) begin
      flush = 1'b1; @(posedge clk); #1; flush = 1'b0;
    end else begin
      @(posedge clk); #1;
      check("drained", out_valid, 1'b0);
    end
  endtask

  task automatic reset_now();
    #2 rst = 1'b1;
    #1;
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_result", out_result, 64'd0);
    check("rst_illegal", out_illegal, 1'b0);
    @(negedge clk); rst = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      check("post_rst_valid", out_valid, 1'b0);
      check("post_rst_ready", in_ready, 1'b1);
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] a, b, er;
    logic        ei;
    int          el, op, n, seen;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_op = '0; in_a = '0; in_b = '0;
    #12;
    check("reset_in_ready", in_ready, 1'b1);
    check("reset_out_valid", out_valid, 1'b0);
    check("reset_result", out_result, 64'd0);
    check("reset_illegal", out_illegal, 1'b0);
    @(negedge clk); rst = 1'b0;

    run_chk(9, MIN64, 64'h43, 64'hF000_0000_0000_0000, 1'b0, 1);
    run_chk(14, 64'h0000_0000_8000_0000, 64'd0, 64'hFFFF_FFFF_8000_0000, 1'b0, 1);
    run_chk(0, 64'd3, 64'd4, 64'd7, 1'b0, 1);
    run_chk(31, 64'd3, 64'd4, 64'd0, 1'b1, 1);
`ifdef ALU_MDU_MULDIV_EN
    run_chk(17, -64'd2, 64'd3, '1, 1'b0, 65);
    run_chk(24, 64'h7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 33);
    run_chk(20, 64'd5, 64'd0, '1, 1'b0, 1);
    run_chk(23, 64'd5, 64'd0, 64'd5, 1'b0, 1);
    run_chk(20, MIN64, '1, MIN64, 1'b0, 1);
    run_chk(22, -64'd7, 64'd2, '1, 1'b0, 65);
`else
    run_chk(16, 64'd3, 64'd4, 64'd0, 1'b1, 1);
    run_chk(20, 64'd5, 64'd0, 64'd0, 1'b1, 1);
`endif

    // Backpressure: result and handshake frozen while out_ready is low
    out_ready = 1'b0;
`ifdef ALU_MDU_MULDIV_EN
    issue(21, 64'd100, 64'd7); er = 64'd14;
`else
    issue(0, 64'd100, 64'd7); er = 64'd107;
`endif
    wait_valid(n);
    repeat (20) begin
      @(posedge clk); #1;
      check("bp_result", out_result, er);
      check("bp_valid", out_valid, 1'b1);
      check("bp_in_ready", in_ready, 1'b0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release", out_valid, 1'b0);

    // Flush wins over a same-cycle request
    @(negedge clk);
    in_valid = 1'b1; flush = 1'b1; in_op = 5'd0; in_a = 64'd1; in_b = 64'd2;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    check("flush_req_valid", out_valid, 1'b0);
    check("flush_req_ready", in_ready, 1'b1);
    @(posedge clk); #1;
    check("flush_req_valid2", out_valid, 1'b0);

    // Flush drops a pending result
    out_ready = 1'b0;
    issue(0, 64'd5, 64'd6);
    wait_valid(n);
    check("flush_done_pre", out_valid, 1'b1);
    @(negedge clk); flush = 1'b1;
    @(posedge clk); #1; flush = 1'b0;
    check("flush_done_valid", out_valid, 1'b0);
    check("flush_done_ready", in_ready, 1'b1);
    out_ready = 1'b1;

`ifdef ALU_MDU_MULDIV_EN
    issue(20, {$urandom, $urandom}, 64'd3);
    repeat (5) @(posedge clk);
    @(negedge clk); flush = 1'b1;
    @(posedge clk); #1; flush = 1'b0;
    check("flush_div_valid", out_valid, 1'b0);
    check("flush_div_ready", in_ready, 1'b1);
    seen = 0;
    repeat (70) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    check("flush_div_no_output", 64'(seen), 64'd0);

    issue(16, {$urandom, $urandom}, {$urandom, $urandom});
    repeat (10) @(posedge clk);
    reset_now();
`endif

    // Asynchronous reset while a result is being held
    out_ready = 1'b0;
    issue(1, 64'd0, 64'd1);
    wait_valid(n);
    check("pre_rst_result", out_result, '1);
    reset_now();
    issue(30, 64'd1, 64'd1);
    wait_valid(n);
    check("pre_rst_illegal", out_illegal, 1'b1);
    reset_now();
    out_ready = 1'b1;

    for (int i = 0; i < 300; i++) begin
      op = $urandom_range(0, 31);
      a  = pick();
      b  = pick();
      ref_model(op, a, b, er, ei, el);
      run_chk(op, a, b, er, ei, el);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
